// File: rtl/mnist_input_deserializer.sv
// Raster pixel stream to packed, quantised image vector for the LogicNet layer-0 LUTs.
// Pixels fill slots 0..NUM_PIXELS-1. The frame is then held with valid/ready until it is taken.
module mnist_input_deserializer #(
   parameter int NUM_PIXELS = 784,
   parameter int PIX_W      = 8,
   parameter int IN_BITS    = 1,
   parameter int THRESH     = 128
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PIX_W-1:0]              s_pix,
   input  logic                          s_valid,
   input  logic                          s_last,
   output logic                          s_ready,
   output logic [NUM_PIXELS*IN_BITS-1:0] m_vec,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          err_len
);

   localparam int                CNT_W    = $clog2(NUM_PIXELS);
   localparam int                VEC_W    = NUM_PIXELS * IN_BITS;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_PIXELS - 1);
   localparam logic [PIX_W-1:0]  THRESH_C = PIX_W'(THRESH);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic               m_valid_q, m_valid_d;
   logic               err_q, err_d;
   logic [IN_BITS-1:0] pix_qnt;
   logic               beat;
   logic               xfer;

   // Single-bit mode thresholds; wider modes keep the pixel's top bits.
   function automatic logic [IN_BITS-1:0] quantise(input logic [PIX_W-1:0] pix);
      logic [IN_BITS-1:0] q;
      q = '0;
      if (IN_BITS == 1) begin
         q[0] = (pix >= THRESH_C);
      end else begin
         q = pix[PIX_W-1 -: IN_BITS];
      end
      return q;
   endfunction

   assign pix_qnt = quantise(s_pix);
   assign s_ready = (state_q == FILL) & ~rst;
   assign beat    = s_valid & s_ready;
   assign xfer    = m_valid_q & m_ready;

   assign m_vec   = vec_q;
   assign m_valid = m_valid_q;
   assign err_len = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         vec_q     <= '0;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vec_q     <= vec_d;
         m_valid_q <= m_valid_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      vec_d     = vec_q;
      m_valid_d = m_valid_q;
      err_d     = 1'b0;
      case (state_q)
         FILL: begin
            if (beat) begin
               for (int i = 0; i < NUM_PIXELS; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     vec_d[i*IN_BITS +: IN_BITS] = pix_qnt;
                  end
               end
               // A full count always delivers the frame; a missing s_last is flagged only.
               if (cnt_q == LAST_CNT) begin
                  state_d   = FULL;
                  m_valid_d = 1'b1;
                  cnt_d     = '0;
                  err_d     = ~s_last;
               end else if (s_last) begin
                  cnt_d = '0;
                  err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FULL: begin
            if (xfer) begin
               state_d   = FILL;
               m_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

endmodule

// File: tb/tb_mnist_input_deserializer.sv
// Directed bench for mnist_input_deserializer: table of 4-pixel frames plus hand-written
// sequences for backpressure, short frame, reset mid-frame and the 2-bit quantiser.
module tb_mnist_input_deserializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_pix;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [3:0] m_vec;
   logic       m_valid;
   logic       m_ready;
   logic       err_len;

   logic [7:0] s_pix2;
   logic       s_valid2;
   logic       s_last2;
   logic       s_ready2;
   logic [7:0] m_vec2;
   logic       m_valid2;
   logic       m_ready2;
   logic       err_len2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mnist_input_deserializer #(
      .NUM_PIXELS(4), .PIX_W(8), .IN_BITS(1), .THRESH(128)
   ) u_dut (
      .clk(clk), .rst(rst), .s_pix(s_pix), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .m_vec(m_vec), .m_valid(m_valid), .m_ready(m_ready),
      .err_len(err_len)
   );

   mnist_input_deserializer #(
      .NUM_PIXELS(4), .PIX_W(8), .IN_BITS(2), .THRESH(128)
   ) u_dut2 (
      .clk(clk), .rst(rst), .s_pix(s_pix2), .s_valid(s_valid2), .s_last(s_last2),
      .s_ready(s_ready2), .m_vec(m_vec2), .m_valid(m_valid2), .m_ready(m_ready2),
      .err_len(err_len2)
   );

   typedef struct {
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] p2;
      logic [7:0] p3;
      logic       last4;
      logic       gapped;
      logic [3:0] exp_vec;
      logic       exp_err;
   } frame_t;

   frame_t tbl[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic put_pix(input logic [7:0] pix, input logic last, input logic gapped);
      int n;
      n = 0;
      while (!s_ready && n < 20) begin
         step();
         n++;
      end
      chk("s_ready_wait", 32'(s_ready), 32'd1);
      s_pix   = pix;
      s_last  = last;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (gapped) begin
         s_pix  = 8'hFF;
         s_last = 1'b1;
         step();
         s_last = 1'b0;
      end
   endtask

   task automatic run_frame(input frame_t f);
      put_pix(f.p0, 1'b0, f.gapped);
      put_pix(f.p1, 1'b0, f.gapped);
      put_pix(f.p2, 1'b0, f.gapped);
      chk("m_valid_early", 32'(m_valid), 32'd0);
      if (!s_ready) begin
         chk("s_ready_last", 32'(s_ready), 32'd1);
      end
      s_pix   = f.p3;
      s_last  = f.last4;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("m_valid_rise", 32'(m_valid), 32'd1);
      chk("m_vec", 32'(m_vec), 32'(f.exp_vec));
      chk("err_len_rise", 32'(err_len), 32'(f.exp_err));
      chk("s_ready_full", 32'(s_ready), 32'd0);
      step();
      chk("m_valid_drop", 32'(m_valid), 32'd0);
      chk("err_len_drop", 32'(err_len), 32'd0);
      chk("s_ready_after", 32'(s_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] pix2 [4];

      tbl[0] = '{8'd200, 8'd10,  8'd128, 8'd127, 1'b1, 1'b0, 4'b0101, 1'b0};
      tbl[1] = '{8'd255, 8'd255, 8'd0,   8'd0,   1'b1, 1'b0, 4'b0011, 1'b0};
      tbl[2] = '{8'd200, 8'd10,  8'd128, 8'd127, 1'b1, 1'b1, 4'b0101, 1'b0};
      tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd255, 1'b0, 1'b0, 4'b1000, 1'b1};
      tbl[4] = '{8'd127, 8'd128, 8'd255, 8'd1,   1'b1, 1'b1, 4'b0110, 1'b0};
      tbl[5] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 4'b0000, 1'b0};

      rst      = 1'b1;
      s_pix    = 8'd0;
      s_valid  = 1'b0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      s_pix2   = 8'd0;
      s_valid2 = 1'b0;
      s_last2  = 1'b0;
      m_ready2 = 1'b1;

      // Reset state
      step();
      step();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_vec", 32'(m_vec), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      m_ready = 1'b1;

      // Frame table
      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i]);
      end

      // Backpressure: vector held 5 cycles, a pending pixel waits for the transfer
      m_ready = 1'b0;
      put_pix(8'd200, 1'b0, 1'b0);
      put_pix(8'd10,  1'b0, 1'b0);
      put_pix(8'd128, 1'b0, 1'b0);
      put_pix(8'd127, 1'b1, 1'b0);
      chk("bp_m_valid_rise", 32'(m_valid), 32'd1);
      s_pix   = 8'd255;
      s_last  = 1'b0;
      s_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_m_valid_hold", 32'(m_valid), 32'd1);
         chk("bp_m_vec_hold", 32'(m_vec), 32'h5);
         chk("bp_s_ready", 32'(s_ready), 32'd0);
      end
      m_ready = 1'b1;
      step();
      chk("bp_xfer_m_valid", 32'(m_valid), 32'd0);
      chk("bp_xfer_s_ready", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b0;
      put_pix(8'd0, 1'b0, 1'b0);
      put_pix(8'd0, 1'b0, 1'b0);
      put_pix(8'd0, 1'b1, 1'b0);
      chk("bp_next_m_valid", 32'(m_valid), 32'd1);
      chk("bp_next_m_vec", 32'(m_vec), 32'h1);
      step();

      // Short frame then a full one
      put_pix(8'd255, 1'b0, 1'b0);
      put_pix(8'd255, 1'b1, 1'b0);
      chk("short_err", 32'(err_len), 32'd1);
      chk("short_m_valid", 32'(m_valid), 32'd0);
      step();
      chk("short_err_drop", 32'(err_len), 32'd0);
      chk("short_m_valid_2", 32'(m_valid), 32'd0);
      run_frame(tbl[1]);

      // Reset mid-frame
      put_pix(8'd255, 1'b0, 1'b0);
      put_pix(8'd255, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      step();
      chk("midrst_m_vec", 32'(m_vec), 32'd0);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      chk("midrst_err", 32'(err_len), 32'd0);
      rst = 1'b0;
      #1;
      put_pix(8'd0,   1'b0, 1'b0);
      put_pix(8'd0,   1'b0, 1'b0);
      put_pix(8'd255, 1'b0, 1'b0);
      put_pix(8'd0,   1'b1, 1'b0);
      chk("midrst_next_m_valid", 32'(m_valid), 32'd1);
      chk("midrst_next_m_vec", 32'(m_vec), 32'h4);
      chk("midrst_next_err", 32'(err_len), 32'd0);
      step();

      // 2-bit quantiser: top bits of each pixel
      pix2[0] = 8'hC0;
      pix2[1] = 8'h40;
      pix2[2] = 8'h80;
      pix2[3] = 8'h3F;
      for (int k = 0; k < 4; k++) begin
         chk("q2_s_ready", 32'(s_ready2), 32'd1);
         s_pix2   = pix2[k];
         s_last2  = (k == 3);
         s_valid2 = 1'b1;
         step();
      end
      s_valid2 = 1'b0;
      s_last2  = 1'b0;
      chk("q2_m_valid", 32'(m_valid2), 32'd1);
      chk("q2_m_vec", 32'(m_vec2), 32'h27);
      chk("q2_err", 32'(err_len2), 32'd0);
      step();
      chk("q2_m_valid_drop", 32'(m_valid2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
